// File: rtl/rv_pkg.sv
// Shared RV32IM decode helpers for the pipeline hazard controller.
// Holds opcode constants, the hazard cause encoding, the MD sequencer state
// type and small decode functions used by the hazard and MD logic.
package rv_pkg;

  localparam logic [6:0] LUI           = 7'b0110111;
  localparam logic [6:0] AUIPC         = 7'b0010111;
  localparam logic [6:0] JAL           = 7'b1101111;
  localparam logic [6:0] JALR          = 7'b1100111;
  localparam logic [6:0] BRANCH        = 7'b1100011;
  localparam logic [6:0] LOAD          = 7'b0000011;
  localparam logic [6:0] STORE         = 7'b0100011;
  localparam logic [6:0] IMM           = 7'b0010011;
  localparam logic [6:0] REG           = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    CauseNone    = 3'd0,
    CauseMd      = 3'd1,
    CauseLoadUse = 3'd2,
    CauseWToD    = 3'd3,
    CauseMToD    = 3'd4
  } hazard_cause_e;

  typedef enum logic {
    StIdle  = 1'b0,
    StMdRun = 1'b1
  } md_state_e;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    case (opcode)
      JALR, BRANCH, LOAD, STORE, IMM, REG: uses_rs1 = 1'b1;
      default:                             uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      BRANCH, STORE, REG: uses_rs2 = 1'b1;
      default:            uses_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode);
    case (opcode)
      LUI, AUIPC, JAL, JALR, LOAD, IMM, REG: writes_rd = 1'b1;
      default:                               writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic is_md(input logic [6:0] opcode, input logic [6:0] funct7);
    is_md = (opcode == REG) && (funct7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/md_seq.sv
// Multiply/divide X-stage occupancy sequencer.
// Ports: clk, rst_n (async active-low); insn_x instruction in X; flush kills X;
// hold_x freezes X (combinational, raised in the cycle the MD op arrives);
// md_busy is high while the sequencer is in its run state.
module md_seq
  import rv_pkg::*;
#(
  parameter int unsigned MD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] insn_x,
  input  logic        flush,
  output logic        hold_x,
  output logic        md_busy
);

  localparam int unsigned CntW    = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam int          LoadVal = (MD_LAT > 1) ? int'(MD_LAT) - 2 : 0;
  localparam logic [CntW-1:0] CntLoad = CntW'(LoadVal);

  md_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic            md_start;

  // The arrival cycle counts as the first held cycle, so the run state only
  // needs MD_LAT-2 further held cycles before the release cycle.
  assign md_start = (state_q == StIdle) && is_md(insn_x[6:0], insn_x[31:25]) &&
                    (MD_LAT > 1) && !flush;
  assign hold_x   = md_start || ((state_q == StMdRun) && (cnt_q != '0) && !flush);
  assign md_busy  = (state_q == StMdRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (md_start) begin
            state_q <= StMdRun;
            cnt_q   <= CntLoad;
          end
        end
        StMdRun: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  logic unused_insn_x;
  assign unused_insn_x = ^insn_x[24:7];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the five-stage RV32IM pipeline.
// Ports: clk, rst_n (async active-low); insn_d/x/m/w stage instructions;
// flush X-stage redirect; cnt_clr clears stall_cnt; insn_x_sel (0 = bubble
// into X); reg_W_disable freezes PC and D; hold_x freezes X; md_busy MD run;
// hazard_cause encoded stall reason; stall_cnt saturating stalled-cycle count.
module pipeline_hazard_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned MD_LAT        = 4,
  parameter bit          W_TO_D_BYPASS = 1'b0,
  parameter bit          M_TO_D_BYPASS = 1'b0,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      insn_d,
  input  logic [31:0]      insn_x,
  input  logic [31:0]      insn_m,
  input  logic [31:0]      insn_w,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             insn_x_sel,
  output logic             reg_W_disable,
  output logic             hold_x,
  output logic             md_busy,
  output logic [2:0]       hazard_cause,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [6:0] op_d;
  logic [4:0] rs1_d, rs2_d, rd_x, rd_m, rd_w;
  logic       d_rs1, d_rs2, d_rs2_lu;
  logic       lu_hit, w_hit, m_hit;
  hazard_cause_e   cause;
  logic [CNT_W-1:0] stall_cnt_q;

  md_seq #(
    .MD_LAT(MD_LAT)
  ) u_md_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .insn_x (insn_x),
    .flush  (flush),
    .hold_x (hold_x),
    .md_busy(md_busy)
  );

  assign op_d  = insn_d[6:0];
  assign rs1_d = insn_d[19:15];
  assign rs2_d = insn_d[24:20];
  assign rd_x  = insn_x[11:7];
  assign rd_m  = insn_m[11:7];
  assign rd_w  = insn_w[11:7];

  assign d_rs1    = uses_rs1(op_d);
  assign d_rs2    = uses_rs2(op_d);
  // A store's rs2 is forwarded in M, so it never waits on a load in X.
  assign d_rs2_lu = (op_d == BRANCH) || (op_d == REG);

  assign lu_hit = (insn_x[6:0] == LOAD) && (rd_x != 5'd0) &&
                  ((d_rs1 && (rs1_d == rd_x)) || (d_rs2_lu && (rs2_d == rd_x)));

  assign w_hit = !W_TO_D_BYPASS && writes_rd(insn_w[6:0]) && (rd_w != 5'd0) &&
                 ((d_rs1 && (rs1_d == rd_w)) || (d_rs2 && (rs2_d == rd_w)));

  // JALR reads its target in D, so any M-stage writer stalls it.
  assign m_hit = !M_TO_D_BYPASS && writes_rd(insn_m[6:0]) && (rd_m != 5'd0) &&
                 ((op_d == JALR) || ((op_d == STORE) && (rs2_d == rd_m)));

  always_comb begin
    insn_x_sel    = 1'b1;
    reg_W_disable = 1'b0;
    cause         = CauseNone;
    if (flush) begin
      cause = CauseNone;
    end else if (hold_x) begin
      reg_W_disable = 1'b1;
      cause         = CauseMd;
    end else if (lu_hit) begin
      insn_x_sel    = 1'b0;
      reg_W_disable = 1'b1;
      cause         = CauseLoadUse;
    end else if (w_hit) begin
      insn_x_sel    = 1'b0;
      reg_W_disable = 1'b1;
      cause         = CauseWToD;
    end else if (m_hit) begin
      insn_x_sel    = 1'b0;
      reg_W_disable = 1'b1;
      cause         = CauseMToD;
    end
  end

  assign hazard_cause = cause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (reg_W_disable && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

  logic unused_insn;
  assign unused_insn = ^{insn_d[31:25], insn_d[14:7], insn_x[31:12],
                         insn_m[31:12], insn_w[31:12]};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: three controller instances with different parameters share
// one stimulus stream; a driver pushes model expectations, a monitor compares.
module tb_pipeline_hazard_ctrl;

  localparam int NI = 3;
  localparam int unsigned LAT [NI] = '{4, 1, 2};
  localparam bit WB [NI] = '{1'b0, 1'b1, 1'b1};
  localparam bit MB [NI] = '{1'b0, 1'b1, 1'b0};
  localparam int unsigned CMAX [NI] = '{32'd15, 32'hffff_ffff, 32'd255};

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f;
  localparam logic [6:0] OP_JALR = 7'h67, OP_BR = 7'h63, OP_LD = 7'h03;
  localparam logic [6:0] OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;
  localparam logic [6:0] OPS [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR,
                                     OP_LD, OP_ST, OP_IMM, OP_REG};
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        sel;
    logic        rwd;
    logic        hold;
    logic        busy;
    logic [2:0]  cause;
    logic [31:0] cnt;
  } exp_t;
  typedef exp_t [NI-1:0] exp_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] insn_d = NOP, insn_x = NOP, insn_m = NOP, insn_w = NOP;
  logic flush = 1'b0, cnt_clr = 1'b0;

  logic        sel [NI], rwd [NI], hold [NI], busy [NI];
  logic [2:0]  cause [NI];
  logic [31:0] act_cnt [NI];
  logic [3:0]  cnt0;
  logic [31:0] cnt1;
  logic [7:0]  cnt2;

  assign act_cnt[0] = {28'd0, cnt0};
  assign act_cnt[1] = cnt1;
  assign act_cnt[2] = {24'd0, cnt2};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_vec_t exp_q[$];
  int age [NI];
  int unsigned scnt [NI];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_LAT(4), .W_TO_D_BYPASS(1'b0), .M_TO_D_BYPASS(1'b0), .CNT_W(4))
    u_dut0 (.clk(clk), .rst_n(rst_n), .insn_d(insn_d), .insn_x(insn_x), .insn_m(insn_m),
            .insn_w(insn_w), .flush(flush), .cnt_clr(cnt_clr), .insn_x_sel(sel[0]),
            .reg_W_disable(rwd[0]), .hold_x(hold[0]), .md_busy(busy[0]),
            .hazard_cause(cause[0]), .stall_cnt(cnt0));

  pipeline_hazard_ctrl #(.MD_LAT(1), .W_TO_D_BYPASS(1'b1), .M_TO_D_BYPASS(1'b1), .CNT_W(32))
    u_dut1 (.clk(clk), .rst_n(rst_n), .insn_d(insn_d), .insn_x(insn_x), .insn_m(insn_m),
            .insn_w(insn_w), .flush(flush), .cnt_clr(cnt_clr), .insn_x_sel(sel[1]),
            .reg_W_disable(rwd[1]), .hold_x(hold[1]), .md_busy(busy[1]),
            .hazard_cause(cause[1]), .stall_cnt(cnt1));

  pipeline_hazard_ctrl #(.MD_LAT(2), .W_TO_D_BYPASS(1'b1), .M_TO_D_BYPASS(1'b0), .CNT_W(8))
    u_dut2 (.clk(clk), .rst_n(rst_n), .insn_d(insn_d), .insn_x(insn_x), .insn_m(insn_m),
            .insn_w(insn_w), .flush(flush), .cnt_clr(cnt_clr), .insn_x_sel(sel[2]),
            .reg_W_disable(rwd[2]), .hold_x(hold[2]), .md_busy(busy[2]),
            .hazard_cause(cause[2]), .stall_cnt(cnt2));

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [6:0] op;
    logic [6:0] f7;
    op = OPS[$urandom_range(0, 8)];
    f7 = ($urandom_range(0, 2) == 0) ? 7'h01 : 7'h00;
    return enc(f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), op);
  endfunction

  function automatic bit rd_rs1(input logic [31:0] i);
    return i[6:0] inside {OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_REG};
  endfunction
  function automatic bit rd_rs2(input logic [31:0] i);
    return i[6:0] inside {OP_BR, OP_ST, OP_REG};
  endfunction
  function automatic bit wr_rd(input logic [31:0] i);
    return i[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_REG};
  endfunction
  function automatic bit mdop(input logic [31:0] i);
    return (i[6:0] == OP_REG) && (i[31:25] == 7'h01);
  endfunction
  // D reads register r as a source.
  function automatic bit reads(input logic [31:0] d, input logic [4:0] r, input bit rs2_ok);
    return (r != 5'd0) && ((rd_rs1(d) && d[19:15] == r) || (rs2_ok && d[24:20] == r));
  endfunction

  // age = number of earlier cycles the current MD op has already spent in X.
  function automatic exp_t model(input int i, input logic fl, input logic [31:0] d,
                                 input logic [31:0] x, input logic [31:0] m,
                                 input logic [31:0] w);
    exp_t e;
    bit h;
    e = '0;
    e.sel = 1'b1;
    e.busy = (age[i] > 0);
    h = !fl && ((age[i] == 0 && mdop(x) && LAT[i] > 1) ||
                (age[i] > 0 && age[i] < int'(LAT[i]) - 1));
    e.hold = h;
    if (fl) begin
      e.cause = 3'd0;
    end else if (h) begin
      e.rwd = 1'b1; e.cause = 3'd1;
    end else if (x[6:0] == OP_LD &&
                 reads(d, x[11:7], d[6:0] == OP_BR || d[6:0] == OP_REG)) begin
      e.sel = 1'b0; e.rwd = 1'b1; e.cause = 3'd2;
    end else if (!WB[i] && wr_rd(w) && reads(d, w[11:7], rd_rs2(d))) begin
      e.sel = 1'b0; e.rwd = 1'b1; e.cause = 3'd3;
    end else if (!MB[i] && wr_rd(m) && m[11:7] != 5'd0 &&
                 (d[6:0] == OP_JALR || (d[6:0] == OP_ST && d[24:20] == m[11:7]))) begin
      e.sel = 1'b0; e.rwd = 1'b1; e.cause = 3'd4;
    end
    return e;
  endfunction

  task automatic drive(input logic [31:0] d, input logic [31:0] x, input logic [31:0] m,
                       input logic [31:0] w, input logic fl, input logic clr,
                       input logic rst);
    exp_vec_t e;
    @(posedge clk);
    #1;
    rst_n = !rst;
    insn_d = d; insn_x = x; insn_m = m; insn_w = w;
    flush = fl; cnt_clr = clr;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        age[i] = 0;
        scnt[i] = 0;
      end
      e[i] = model(i, fl, d, x, m, w);
      e[i].cnt = scnt[i];
      if (!rst) begin
        if (clr) scnt[i] = 0;
        else if (e[i].rwd && scnt[i] < CMAX[i]) scnt[i] = scnt[i] + 1;
        if (fl) age[i] = 0;
        else if (age[i] > 0) age[i] = (age[i] < int'(LAT[i]) - 1) ? age[i] + 1 : 0;
        else age[i] = (mdop(x) && LAT[i] > 1) ? 1 : 0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL cyc=%0d %s actual=%0h required=%0h", cyc, nm, act, req);
    end
  endtask

  initial begin : monitor
    exp_vec_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        for (int i = 0; i < NI; i++) begin
          check($sformatf("u%0d insn_x_sel", i), {31'd0, sel[i]}, {31'd0, e[i].sel});
          check($sformatf("u%0d reg_W_disable", i), {31'd0, rwd[i]}, {31'd0, e[i].rwd});
          check($sformatf("u%0d hold_x", i), {31'd0, hold[i]}, {31'd0, e[i].hold});
          check($sformatf("u%0d md_busy", i), {31'd0, busy[i]}, {31'd0, e[i].busy});
          check($sformatf("u%0d hazard_cause", i), {29'd0, cause[i]}, {29'd0, e[i].cause});
          check($sformatf("u%0d stall_cnt", i), act_cnt[i], e[i].cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [31:0] lw5, add6, lw0, add6_0, addi7, sw7, lui9, jalr1, mul3;
    lw5    = enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, OP_LD);
    add6   = enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, OP_REG);
    lw0    = enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd0, OP_LD);
    add6_0 = enc(7'h00, 5'd2, 5'd0, 3'd0, 5'd6, OP_REG);
    addi7  = enc(7'h00, 5'd1, 5'd0, 3'd0, 5'd7, OP_IMM);
    sw7    = enc(7'h00, 5'd7, 5'd3, 3'd2, 5'd0, OP_ST);
    lui9   = enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd9, OP_LUI);
    jalr1  = enc(7'h00, 5'd0, 5'd4, 3'd0, 5'd1, OP_JALR);
    mul3   = enc(7'h01, 5'd2, 5'd1, 3'd0, 5'd3, OP_REG);
    for (int i = 0; i < NI; i++) begin
      age[i] = 0;
      scnt[i] = 0;
    end

    repeat (2) drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b1);
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0);
    // Load-use, then the same pair through x0.
    drive(add6, lw5, NOP, NOP, 1'b0, 1'b0, 1'b0);
    drive(add6_0, lw0, NOP, NOP, 1'b0, 1'b0, 1'b0);
    // W->D store-rs2 match; M->D JALR with rs1 mismatch.
    drive(sw7, NOP, NOP, addi7, 1'b0, 1'b0, 1'b0);
    drive(jalr1, NOP, lui9, NOP, 1'b0, 1'b0, 1'b0);
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0);
    // MD occupancy followed by idle.
    repeat (4) drive(NOP, mul3, NOP, NOP, 1'b0, 1'b0, 1'b0);
    repeat (2) drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0);
    // Flush on the second MD cycle.
    drive(NOP, mul3, NOP, NOP, 1'b0, 1'b0, 1'b0);
    drive(NOP, mul3, NOP, NOP, 1'b1, 1'b0, 1'b0);
    repeat (2) drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0);
    // Reset in the middle of an MD run.
    repeat (2) drive(NOP, mul3, NOP, NOP, 1'b0, 1'b0, 1'b0);
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b1);
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0);
    // Back-to-back MD ops.
    repeat (8) drive(mul3, mul3, NOP, NOP, 1'b0, 1'b0, 1'b0);
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b1, 1'b0);
    // Saturation of the narrow counter, then a clear coincident with a stall.
    repeat (20) drive(add6, lw5, NOP, NOP, 1'b0, 1'b0, 1'b0);
    drive(add6, lw5, NOP, NOP, 1'b0, 1'b1, 1'b0);
    repeat (2) drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 2000; n++) begin
      drive(rand_insn(), ($urandom_range(0, 3) == 0) ? NOP : rand_insn(), rand_insn(),
            rand_insn(), $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 399) == 0);
    end

    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: actual=%0d entries left required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
